priority_encoder_arbiter: RTL and testbench

Parametrised, registered priority encoder with grant hold and selectable fixed or round-robin priority. It turns NUM_REQ request lines into a held grant: an index, a one-hot vector and a valid flag. The grant stays until the requester releases it. It is the next generation of the family's combinational 4-2 high-priority encoder and sits between shared-resource requesters and the resource mux select.

---
 rtl/priority_encoder_pkg.sv | 23 ++
 rtl/rr_priority_pick.sv | 60 ++++++
 rtl/priority_encoder_arbiter.sv | 107 ++++++++++
 tb/tb_priority_encoder_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/priority_encoder_pkg.sv
// Shared types and helpers for the registered priority encoder / arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: arbiter state enum, mode encodings, index-to-one-hot helper.
package priority_encoder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Widest supported request vector; callers truncate to their own width.
  localparam int MAX_REQ = 64;

  function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [5:0] idx);
    return {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Winner selection: lowest set request at or above a start pointer, wrapping.
// Latency: purely combinational.
// Backpressure: none; caller decides when the result is used.
//
// Ports: req (request vector), start_ptr (round-robin start index),
//        mode (MODE_FIXED forces start to 0), hit (any request set),
//        idx (winning index, 0 when no hit).
module rr_priority_pick
  import priority_encoder_pkg::*;
#(
  parameter  int NUM_REQ = 8,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start_ptr,
  input  logic               mode,
  output logic               hit,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0]   base;
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] masked;
  logic               hi_hit;
  logic [IDX_W-1:0]   hi_idx;
  logic               lo_hit;
  logic [IDX_W-1:0]   lo_idx;

  always_comb begin
    base = (mode == MODE_RR) ? start_ptr : '0;

    mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask[i] = (i >= int'(base));
    end
    masked = req & mask;

    // Scan from the top down so the last assignment is the lowest set bit.
    // First pass (masked) covers [base, NUM_REQ-1]; second pass (unmasked)
    // supplies the wrap-around winner when nothing is set above base.
    hi_hit = 1'b0;
    hi_idx = '0;
    lo_hit = 1'b0;
    lo_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (masked[i]) begin
        hi_hit = 1'b1;
        hi_idx = IDX_W'(i);
      end
      if (req[i]) begin
        lo_hit = 1'b1;
        lo_idx = IDX_W'(i);
      end
    end

    hit = lo_hit;
    idx = hi_hit ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/priority_encoder_arbiter.sv
// Registered priority encoder with grant hold; fixed or round-robin priority.
// Latency: request->grant 1 cycle, release/withdraw->idle 1 cycle, one idle cycle between grants.
// Backpressure: a held grant blocks all other requesters until Release_In or withdrawal.
//
// Ports: Clock_In, Reset_In (sync, active-low), Enable_In (gates new grants),
//        Mode_In (0 fixed, 1 round-robin), Request_In[NUM_REQ], Release_In,
//        Grant_Valid_Out, Grant_Index_Out[IDX_W], Grant_Onehot_Out[NUM_REQ].
module priority_encoder_arbiter
  import priority_encoder_pkg::*;
#(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               Clock_In,
  input  logic               Reset_In,
  input  logic               Enable_In,
  input  logic               Mode_In,
  input  logic [NUM_REQ-1:0] Request_In,
  input  logic               Release_In,
  output logic               Grant_Valid_Out,
  output logic [IDX_W-1:0]   Grant_Index_Out,
  output logic [NUM_REQ-1:0] Grant_Onehot_Out
);

  state_t             state_q;
  state_t             state_d;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   rr_ptr_d;
  logic               vld_d;
  logic [IDX_W-1:0]   idx_d;
  logic [NUM_REQ-1:0] onehot_d;

  logic               pick_hit;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   pick_next_ptr;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req       (Request_In),
    .start_ptr (rr_ptr_q),
    .mode      (Mode_In),
    .hit       (pick_hit),
    .idx       (pick_idx)
  );

  // Pointer moves to the slot after the winner, wrapping at NUM_REQ rather
  // than at 2**IDX_W so non-power-of-two sizes never visit unused indices.
  assign pick_next_ptr = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + IDX_W'(1);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    vld_d    = Grant_Valid_Out;
    idx_d    = Grant_Index_Out;
    onehot_d = Grant_Onehot_Out;

    case (state_q)
      IDLE: begin
        vld_d    = 1'b0;
        idx_d    = '0;
        onehot_d = '0;
        if (Enable_In && pick_hit) begin
          state_d  = GRANT;
          vld_d    = 1'b1;
          idx_d    = pick_idx;
          onehot_d = NUM_REQ'(idx_to_onehot(6'(pick_idx)));
          if (Mode_In == MODE_RR) begin
            rr_ptr_d = pick_next_ptr;
          end
        end
      end
      GRANT: begin
        // Release and withdrawal together are a single release.
        if (Release_In || !Request_In[Grant_Index_Out]) begin
          state_d  = IDLE;
          vld_d    = 1'b0;
          idx_d    = '0;
          onehot_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        vld_d    = 1'b0;
        idx_d    = '0;
        onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clock_In) begin
    if (!Reset_In) begin
      state_q          <= IDLE;
      rr_ptr_q         <= '0;
      Grant_Valid_Out  <= 1'b0;
      Grant_Index_Out  <= '0;
      Grant_Onehot_Out <= '0;
    end else begin
      state_q          <= state_d;
      rr_ptr_q         <= rr_ptr_d;
      Grant_Valid_Out  <= vld_d;
      Grant_Index_Out  <= idx_d;
      Grant_Onehot_Out <= onehot_d;
    end
  end

endmodule

// File: tb/tb_priority_encoder_arbiter.sv
// Self-checking bench: three arbiter instances (8, 5 and 2 requesters) against a reference model.
// Latency: model predicts post-edge outputs; monitor compares on the falling edge.
// Backpressure: n/a.
module tb_priority_encoder_arbiter;

  typedef struct packed {
    logic       vld;
    logic [7:0] idx;
    logic [7:0] oh;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, en, mode, rel;
  logic [7:0] req8;
  logic [4:0] req5;
  logic [1:0] req2;

  logic       v8, v5, v2;
  logic [2:0] i8, i5;
  logic [0:0] i2;
  logic [7:0] o8;
  logic [4:0] o5;
  logic [1:0] o2;

  exp_t q8[$];
  exp_t q5[$];
  exp_t q2[$];
  int   log8[$];
  int   log5[$];
  int   n_total = 0;
  int   n_pass  = 0;

  initial forever #5 clk = ~clk;

  priority_encoder_arbiter #(.NUM_REQ(8)) dut8 (
    .Clock_In(clk), .Reset_In(rst_n), .Enable_In(en), .Mode_In(mode),
    .Request_In(req8), .Release_In(rel),
    .Grant_Valid_Out(v8), .Grant_Index_Out(i8), .Grant_Onehot_Out(o8)
  );

  priority_encoder_arbiter #(.NUM_REQ(5)) dut5 (
    .Clock_In(clk), .Reset_In(rst_n), .Enable_In(en), .Mode_In(mode),
    .Request_In(req5), .Release_In(rel),
    .Grant_Valid_Out(v5), .Grant_Index_Out(i5), .Grant_Onehot_Out(o5)
  );

  priority_encoder_arbiter #(.NUM_REQ(2)) dut2 (
    .Clock_In(clk), .Reset_In(rst_n), .Enable_In(en), .Mode_In(mode),
    .Request_In(req2), .Release_In(rel),
    .Grant_Valid_Out(v2), .Grant_Index_Out(i2), .Grant_Onehot_Out(o2)
  );

  // Reference winner: walk the requesters in priority order starting from the
  // pointer (round-robin) or from 0 (fixed) and take the first one asking.
  function automatic int winner(input int n, input logic [7:0] r, input logic rr, input int ptr);
    for (int k = 0; k < n; k++) begin
      int c;
      c = rr ? (ptr + k) % n : k;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic check_out(input string name, input exp_t got, input exp_t exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got vld=%0b idx=%0d onehot=%h, expected vld=%0b idx=%0d onehot=%h",
                  name, got.vld, got.idx, got.oh, exp.vld, exp.idx, exp.oh);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Reference model: on each rising edge predict the outputs that follow it.
  initial begin
    logic       held [3];
    int         gidx [3];
    int         ptr  [3];
    int         n;
    int         w;
    logic [7:0] r;
    exp_t       e;
    for (int i = 0; i < 3; i++) begin
      held[i] = 1'b0; gidx[i] = 0; ptr[i] = 0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        n = (i == 0) ? 8 : (i == 1) ? 5 : 2;
        r = (i == 0) ? req8 : (i == 1) ? {3'b000, req5} : {6'b000000, req2};
        if (!rst_n) begin
          held[i] = 1'b0; gidx[i] = 0; ptr[i] = 0;
        end else if (held[i]) begin
          if (rel || !r[gidx[i]]) begin
            held[i] = 1'b0; gidx[i] = 0;
          end
        end else if (en && r != 8'd0) begin
          w = winner(n, r, mode, ptr[i]);
          held[i] = 1'b1;
          gidx[i] = w;
          if (mode) ptr[i] = (w + 1) % n;
        end
        e.vld = held[i];
        e.idx = held[i] ? 8'(gidx[i]) : 8'd0;
        e.oh  = held[i] ? 8'(1 << gidx[i]) : 8'd0;
        if (i == 0) q8.push_back(e);
        else if (i == 1) q5.push_back(e);
        else q2.push_back(e);
      end
    end
  end

  // Monitor: on each falling edge pop one expectation per instance and compare.
  initial begin
    exp_t e;
    logic p8 = 1'b0;
    logic p5 = 1'b0;
    forever begin
      @(negedge clk);
      if (q8.size() == 0) begin
        n_total++; $display("FAIL out8: no expected entry, got vld=%0b", v8);
      end else begin
        e = q8.pop_front();
        check_out("out8", {v8, 8'(i8), o8}, e);
      end
      if (q5.size() == 0) begin
        n_total++; $display("FAIL out5: no expected entry, got vld=%0b", v5);
      end else begin
        e = q5.pop_front();
        check_out("out5", {v5, 8'(i5), 8'(o5)}, e);
      end
      if (q2.size() == 0) begin
        n_total++; $display("FAIL out2: no expected entry, got vld=%0b", v2);
      end else begin
        e = q2.pop_front();
        check_out("out2", {v2, 8'(i2), 8'(o2)}, e);
      end
      if (v8 === 1'b1 && !p8) log8.push_back(int'(i8));
      if (v5 === 1'b1 && !p5) log5.push_back(int'(i5));
      p8 = (v8 === 1'b1);
      p5 = (v5 === 1'b1);
    end
  end

  task automatic step(input logic r, input logic e, input logic m, input logic [7:0] rq, input logic rl);
    rst_n = r; en = e; mode = m; rel = rl;
    req8 = rq; req5 = rq[4:0]; req2 = rq[1:0];
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp8 [11];
    int exp5 [11];
    exp8 = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 7, 0};
    exp5 = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 0, 0};

    // Reset held with every line requesting, then idle with no requests.
    repeat (3) step(1'b0, 1'b1, 1'b0, 8'hFF, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

    // Fixed priority: grant 3, hold against a new low-index request, release, then 0.
    step(1'b1, 1'b1, 1'b0, 8'hA8, 1'b0);
    repeat (2) step(1'b1, 1'b1, 1'b0, 8'hA9, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'hA9, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'hA9, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'hA9, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

    // Round-robin rotation with all lines requesting, then the wrap case.
    log8.delete();
    log5.delete();
    repeat (9) begin
      step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0);
      step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1);
    end
    repeat (2) begin
      step(1'b1, 1'b1, 1'b1, 8'h81, 1'b0);
      step(1'b1, 1'b1, 1'b1, 8'h81, 1'b1);
    end
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    check_int("rr_seq8_len", log8.size(), 11);
    check_int("rr_seq5_len", log5.size(), 11);
    for (int k = 0; k < 11; k++) begin
      if (k < log8.size()) check_int($sformatf("rr_seq8[%0d]", k), log8[k], exp8[k]);
      if (k < log5.size()) check_int($sformatf("rr_seq5[%0d]", k), log5[k], exp5[k]);
    end

    // Withdrawal ends the grant without a release.
    repeat (2) step(1'b1, 1'b1, 1'b0, 8'h20, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

    // Enable gating, grant kept while enable/mode change, reset mid-grant.
    repeat (2) step(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1);

    // Randomized traffic; requests mostly persist so grants are held a while.
    for (int c = 0; c < 2000; c++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      en    = ($urandom_range(0, 7) != 0);
      mode  = 1'($urandom);
      rel   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) req8 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) req5 = 5'($urandom);
      if ($urandom_range(0, 3) == 0) req2 = 2'($urandom);
      @(posedge clk);
      #1;
    end

    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
